dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port synchronous data RAM between the pipeline MEM stage and one external requester (debug/DMA port). The pipeline has priority. A starvation counter guarantees the external port a slot after a bounded wait, and the pipeline is stalled for that cycle. The block sits between the MEM stage and the data RAM. It issues at most one RAM access per cycle and routes read data back to the owner one cycle later.

## Interface
- MAX_WAIT, default 4: cycles the external port may be denied before it is forced in; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  asynchronous reset, active-high (1 = reset).
- p_req  in  1  MEM stage requests access (load or store).
- p_we  in  1  1 = pipeline write, 0 = read.
- p_addr  in  32  pipeline address.
- p_wdata  in  32  pipeline store data.
- p_stall  out  1  pipeline request not granted this cycle; MEM stage must hold.
- p_rvalid  out  1  pipeline read data valid this cycle.
- p_rdata  out  32  pipeline read data.
- e_req  in  1  external request; held with stable e_we/e_addr/e_wdata until e_gnt.
- e_we  in  1  1 = external write.
- e_addr  in  32  external address.
- e_wdata  in  32  external write data.
- e_gnt  out  1  external request issued to the RAM this cycle.
- e_rvalid  out  1  external read data valid this cycle.
- e_rdata  out  32  external read data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid one cycle after the read is issued.

## Operation
- Registered state: `owner` {IDLE, P_RD, E_RD}, which records who has read data returning next cycle; and `wait_cnt` (4 bits, saturating at MAX_WAIT).
- Winner is decided combinationally each cycle:
  - force = e_req && (wait_cnt == MAX_WAIT).
  - If force, the external port wins.
  - Otherwise, if p_req, the pipeline wins.
  - Otherwise, if e_req, the external port wins.
  - Otherwise there is no winner.
- When the pipeline wins:
  - ram_addr = p_addr, ram_din = p_wdata, ram_we = p_we.
  - p_stall = 0.
- When the external port wins:
  - ram_addr = e_addr, ram_din = e_wdata, ram_we = e_we.
  - e_gnt = 1.
  - p_stall = p_req.
- With no winner: ram_we = 0, ram_addr = 0, ram_din = 0.
- p_stall = p_req && !pipeline_wins.
- Next `owner`:
  - P_RD if the pipeline wins with a read.
  - E_RD if the external port wins with a read.
  - IDLE otherwise, including all writes.
- Read return:
  - When owner == P_RD: p_rvalid = 1, p_rdata = ram_dout.
  - When owner == E_RD: e_rvalid = 1, e_rdata = ram_dout.
  - Non-valid rdata outputs are driven to 0.
- Next `wait_cnt`:
  - 0 if e_gnt or !e_req.
  - min(wait_cnt+1, MAX_WAIT) if e_req && !e_gnt.
- Fairness: after a forced external grant the counter clears, so the pipeline wins at least MAX_WAIT consecutive contested cycles.
- Address/data widths pass through unchanged; the arbiter does no address decode or alignment.

## Timing
- Reset (clrn = 1, asynchronous): owner = IDLE, wait_cnt = 0.
  - Hence p_rvalid = e_rvalid = 0 and both rdata outputs = 0.
  - Combinational outputs follow their inputs.
- Reset asserted with a read pending: the pending rvalid is dropped and is never delivered.
- Grant/stall latency: 0 cycles (combinational). The write is committed at the rising edge that ends the grant cycle.
- Read latency: 1 cycle. Data for a read granted in cycle N appears in cycle N+1.
- Back-to-back reads by the same or alternating owners are allowed every cycle, at one access per cycle.
- Simultaneous p_req and e_req with wait_cnt < MAX_WAIT: the pipeline wins; e_gnt = 0; wait_cnt increments.
- An external requester dropping e_req before grant is legal. The counter clears and no access is issued.

## Test plan
- Reset then idle: clrn pulse with no requests -> all outputs 0, ram_we = 0; p_rvalid and e_rvalid stay 0.
- Pipeline write 0xDEADBEEF to 0x10, then read 0x10 -> p_stall = 0 both cycles; p_rvalid = 1 with p_rdata = 0xDEADBEEF one cycle after the read grant.
- External read only (p_req = 0) at 0x20 holding 0x12345678 -> e_gnt same cycle; e_rvalid = 1 with e_rdata = 0x12345678 next cycle.
- Starvation, MAX_WAIT = 4: p_req and e_req held high continuously -> e_gnt = 0 for 4 cycles, then e_gnt = 1 and p_stall = 1 in cycle 5; pattern repeats every 5 cycles.
- Mixed return routing: pipeline read in cycle N, forced external read in N+1 -> p_rvalid in N+1 and e_rvalid in N+2, each with the correct data; never both valid in one cycle.
- Reset mid-operation: clrn asserted in the cycle after a pipeline read grant -> p_rvalid = 0 immediately; wait_cnt = 0; arbitration restarts with pipeline priority.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the MEM-stage, external-requester and data-RAM sides of the data memory arbiter.
// slave = arbiter view; master = the surroundings (pipeline, external port, RAM).
interface dmem_arbiter_if;
   logic        p_req;
   logic        p_we;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic        p_stall;
   logic        p_rvalid;
   logic [31:0] p_rdata;

   logic        e_req;
   logic        e_we;
   logic [31:0] e_addr;
   logic [31:0] e_wdata;
   logic        e_gnt;
   logic        e_rvalid;
   logic [31:0] e_rdata;

   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata,
      output p_stall, p_rvalid, p_rdata,
      input  e_req, e_we, e_addr, e_wdata,
      output e_gnt, e_rvalid, e_rdata,
      output ram_we, ram_addr, ram_din,
      input  ram_dout
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata,
      input  p_stall, p_rvalid, p_rdata,
      output e_req, e_we, e_addr, e_wdata,
      input  e_gnt, e_rvalid, e_rdata,
      input  ram_we, ram_addr, ram_din,
      output ram_dout
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: pipeline priority, external port forced in after MAX_WAIT denials.
// Grant/stall combinational (0 cycles); read data routed to its owner 1 cycle after the grant.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          clrn,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      P_RD = 2'd1,
      E_RD = 2'd2
   } owner_t;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   owner_t     owner, owner_nxt;
   logic [3:0] wait_cnt, wait_nxt;
   logic       force_e;
   logic       e_win;
   logic       p_win;

   // clrn is active-high despite its name
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         owner    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         owner    <= owner_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      force_e      = bus.e_req && (wait_cnt == MAX_W);
      e_win        = force_e || (bus.e_req && !bus.p_req);
      p_win        = bus.p_req && !force_e;

      bus.ram_we   = 1'b0;
      bus.ram_addr = 32'd0;
      bus.ram_din  = 32'd0;
      bus.e_gnt    = 1'b0;
      bus.p_stall  = bus.p_req && !p_win;
      owner_nxt    = IDLE;

      if (e_win) begin
         bus.ram_we   = bus.e_we;
         bus.ram_addr = bus.e_addr;
         bus.ram_din  = bus.e_wdata;
         bus.e_gnt    = 1'b1;
         owner_nxt    = bus.e_we ? IDLE : E_RD;
      end else if (p_win) begin
         bus.ram_we   = bus.p_we;
         bus.ram_addr = bus.p_addr;
         bus.ram_din  = bus.p_wdata;
         owner_nxt    = bus.p_we ? IDLE : P_RD;
      end

      if (!bus.e_req || e_win)
         wait_nxt = 4'd0;
      else if (wait_cnt >= MAX_W)
         wait_nxt = MAX_W;
      else
         wait_nxt = wait_cnt + 4'd1;

      // Return path: data belongs to whoever was granted a read last cycle
      bus.p_rvalid = (owner == P_RD);
      bus.e_rvalid = (owner == E_RD);
      bus.p_rdata  = (owner == P_RD) ? bus.ram_dout : 32'd0;
      bus.e_rdata  = (owner == E_RD) ? bus.ram_dout : 32'd0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a grant/return reference model.
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 4;

   logic clk;
   logic clrn;
   int   n_checks;
   int   n_fail;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous single-port RAM, indexed by the low address byte
   logic [31:0] ram_mem [256];
   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_din;
      bus.ram_dout <= ram_mem[bus.ram_addr[7:0]];
   end

   // Reference model state
   logic [31:0] shadow [256];
   int          denied;
   int          pend_who;     // 0 none, 1 pipeline, 2 external
   logic [31:0] pend_data;

   logic        obs_pstall, obs_egnt, obs_prv, obs_erv;
   logic [31:0] obs_prd, obs_erd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
      end
   endtask

   // One arbitration cycle: drive, check against the model, advance the model
   task automatic cyc(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                      input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
      logic        x_force, x_e, x_p, x_we;
      logic [31:0] x_addr, x_din;
      @(negedge clk);
      bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
      bus.e_req = er; bus.e_we = ew; bus.e_addr = ea; bus.e_wdata = ed;
      #1;
      x_force = er && (denied >= MAX_WAIT);
      x_e     = er && (x_force || !pr);
      x_p     = pr && !x_e;
      x_we    = x_p ? pw : (x_e ? ew : 1'b0);
      x_addr  = x_p ? pa : (x_e ? ea : 32'd0);
      x_din   = x_p ? pd : (x_e ? ed : 32'd0);

      obs_pstall = bus.p_stall;  obs_egnt = bus.e_gnt;
      obs_prv    = bus.p_rvalid; obs_erv  = bus.e_rvalid;
      obs_prd    = bus.p_rdata;  obs_erd  = bus.e_rdata;

      chk("p_stall",  32'(bus.p_stall),  32'(pr && !x_p));
      chk("e_gnt",    32'(bus.e_gnt),    32'(x_e));
      chk("ram_we",   32'(bus.ram_we),   32'(x_we));
      chk("ram_addr", bus.ram_addr,      x_addr);
      chk("ram_din",  bus.ram_din,       x_din);
      chk("p_rvalid", 32'(bus.p_rvalid), 32'(pend_who == 1));
      chk("e_rvalid", 32'(bus.e_rvalid), 32'(pend_who == 2));
      chk("p_rdata",  bus.p_rdata,       (pend_who == 1) ? pend_data : 32'd0);
      chk("e_rdata",  bus.e_rdata,       (pend_who == 2) ? pend_data : 32'd0);

      pend_who = 0;
      if ((x_p || x_e) && !x_we) begin
         pend_who  = x_p ? 1 : 2;
         pend_data = shadow[x_addr[7:0]];
      end
      if (x_we) shadow[x_addr[7:0]] = x_din;
      denied = (!er || x_e) ? 0 : denied + 1;
      @(posedge clk);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom();
      a[7:4] = 4'h0;
      return a;
   endfunction

   logic        e_r, e_w;
   logic [31:0] e_a, e_d;

   initial begin
      n_checks = 0; n_fail = 0;
      denied = 0; pend_who = 0; pend_data = 32'd0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 32'd0;
         shadow[i]  = 32'd0;
      end
      clrn = 1'b1;
      bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
      bus.e_req = 0; bus.e_we = 0; bus.e_addr = 0; bus.e_wdata = 0;

      // Reset then idle
      #3;
      chk("rst_p_rvalid", 32'(bus.p_rvalid), 32'd0);
      chk("rst_e_rvalid", 32'(bus.e_rvalid), 32'd0);
      chk("rst_p_rdata",  bus.p_rdata, 32'd0);
      chk("rst_e_rdata",  bus.e_rdata, 32'd0);
      chk("rst_ram_we",   32'(bus.ram_we), 32'd0);
      chk("rst_e_gnt",    32'(bus.e_gnt), 32'd0);
      #4 clrn = 1'b0;
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Pipeline write then read back
      cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("pw_stall", 32'(obs_pstall), 32'd0);
      cyc(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
      chk("pr_stall", 32'(obs_pstall), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pr_valid", 32'(obs_prv), 32'd1);
      chk("pr_data",  obs_prd, 32'hDEADBEEF);

      // External read with the pipeline idle
      cyc(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
      chk("er_gnt", 32'(obs_egnt), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("er_valid", 32'(obs_erv), 32'd1);
      chk("er_data",  obs_erd, 32'h12345678);

      // Starvation: both requesting continuously, external forced in every 5th cycle
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
         chk("starve_gnt",   32'(obs_egnt),   32'(i % 5 == 4));
         chk("starve_stall", 32'(obs_pstall), 32'(i % 5 == 4));
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Mixed routing: pipeline read in N, forced external read in N+1
      for (int i = 0; i < 3; i++) cyc(1, 1, 32'h30 + 32'(i), 32'hA0 + 32'(i), 1, 0, 32'h10, 0);
      cyc(1, 0, 32'h20, 0, 1, 0, 32'h10, 0);
      cyc(1, 0, 32'h20, 0, 1, 0, 32'h10, 0);
      chk("mix_gnt",   32'(obs_egnt), 32'd1);
      chk("mix_p_rv",  32'(obs_prv),  32'd1);
      chk("mix_e_rv0", 32'(obs_erv),  32'd0);
      chk("mix_p_rd",  obs_prd, 32'h12345678);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("mix_e_rv",  32'(obs_erv), 32'd1);
      chk("mix_p_rv0", 32'(obs_prv), 32'd0);
      chk("mix_e_rd",  obs_erd, 32'hDEADBEEF);

      // Reset in the cycle after a pipeline read grant, with the external port part-starved
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      @(negedge clk);
      clrn = 1'b1;
      bus.p_req = 0; bus.e_req = 0;
      #1;
      chk("mid_rst_p_rv", 32'(bus.p_rvalid), 32'd0);
      chk("mid_rst_p_rd", bus.p_rdata, 32'd0);
      pend_who = 0;
      denied   = 0;
      @(posedge clk);
      #1 clrn = 1'b0;
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      chk("rst_prio_gnt",   32'(obs_egnt),   32'd0);
      chk("rst_prio_stall", 32'(obs_pstall), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic; external request held stable until granted, may be withdrawn
      e_r = 0; e_w = 0; e_a = 0; e_d = 0;
      for (int i = 0; i < 600; i++) begin
         if (e_r && !obs_egnt) begin
            if ($urandom_range(0, 9) == 0) e_r = 0;
         end else begin
            e_r = ($urandom_range(0, 9) < 4);
            e_w = $urandom_range(0, 1) == 1;
            e_a = rnd_addr();
            e_d = $urandom();
         end
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
             e_r, e_w, e_a, e_d);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
